// File: rtl/arith_unit_fifo_pkg.sv
// rtl/arith_unit_fifo_pkg.sv - shared opcodes, FSM states and width helper
package arith_unit_fifo_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_e;

    // Number of bits needed to index value distinct items (ceil(log2(value)))
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arith_unit_fifo_result_fifo.sv
// rtl/arith_unit_fifo_result_fifo.sv - circular result queue with pass-through when full
module result_fifo
    import arith_unit_fifo_pkg::*;
#(
    parameter int  WIDTH = 11,
    parameter int  DEPTH = 2,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             not_full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             deq_fire;
    logic             enq_fire;

    assign not_empty = (count != '0);
    assign not_full  = (count != CW'(DEPTH));
    assign deq_fire  = deq && not_empty;
    // A full queue still accepts a write when the head leaves on the same edge
    assign enq_fire  = enq && (not_full || deq_fire);
    // Empty entries are masked so the head never shows stale data
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Storage write and pointer advance; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous enqueue and dequeue leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arith_unit_fifo.sv
// rtl/arith_unit_fifo.sv - add/sub/xor/shift-add multiply unit feeding a result FIFO
module arith_unit_fifo
    import arith_unit_fifo_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] start_a,
    input  logic [WIDTH-1:0] start_b,
    input  logic [1:0]       start_op,
    input  logic             EN_start,
    output logic             RDY_start,
    output logic [WIDTH-1:0] result,
    output logic             RDY_result,
    input  logic             EN_check,
    output logic [WIDTH-1:0] check,
    output logic             RDY_check
);

    localparam int CNTW = clog2(WIDTH + 1);
    localparam int CW   = clog2(DEPTH + 1);

    state_e           state;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] acc_next;
    logic             start_fire;
    logic             wb_go;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_not_empty;
    logic             fifo_not_full;
    logic [CW-1:0]    fifo_count;

    assign RDY_start  = (state == IDLE);
    assign start_fire = EN_start && RDY_start;
    assign acc_next   = mb[0] ? acc + ma : acc;
    // Write-back proceeds if there is room or the head is leaving this edge
    assign wb_go      = (state == WB) && (fifo_not_full || (EN_check && fifo_not_empty));

    assign RDY_result = (fifo_count != '0);
    assign RDY_check  = (fifo_count != '0);
    assign result     = fifo_head;
    assign check      = fifo_head;

    // Control FSM: one operation in flight, multiply iterates WIDTH times
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        state <= (op_e'(start_op) == OP_MUL) ? MUL : WB;
                    end
                end
                MUL: begin
                    if (cnt == CNTW'(1)) begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (wb_go) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: single-cycle ops load the result directly; multiply shifts and accumulates
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_reg <= '0;
            acc     <= '0;
            ma      <= '0;
            mb      <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && start_fire) begin
                case (op_e'(start_op))
                    OP_ADD: res_reg <= start_a + start_b;
                    OP_SUB: res_reg <= start_a - start_b;
                    OP_XOR: res_reg <= start_a ^ start_b;
                    default: begin
                        acc <= '0;
                        ma  <= start_a;
                        mb  <= start_b;
                        cnt <= CNTW'(WIDTH);
                    end
                endcase
            end else if (state == MUL) begin
                acc <= acc_next;
                ma  <= ma << 1;
                mb  <= mb >> 1;
                cnt <= cnt - 1'b1;
                if (cnt == CNTW'(1)) begin
                    res_reg <= acc_next;
                end
            end
        end
    end

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .enq       (wb_go),
        .enq_data  (res_reg),
        .deq       (EN_check),
        .head      (fifo_head),
        .not_empty (fifo_not_empty),
        .not_full  (fifo_not_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_arith_unit_fifo.sv
// tb/tb_arith_unit_fifo.sv - scoreboard bench for arith_unit_fifo
module tb_arith_unit_fifo;

    localparam int W = 11;
    localparam int D = 2;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] start_a = '0;
    logic [W-1:0] start_b = '0;
    logic [1:0]   start_op = '0;
    logic         EN_start = 1'b0;
    logic         RDY_start;
    logic [W-1:0] result;
    logic         RDY_result;
    logic         EN_check = 1'b0;
    logic [W-1:0] check;
    logic         RDY_check;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] sb [$];

    arith_unit_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start_a    (start_a),
        .start_b    (start_b),
        .start_op   (start_op),
        .EN_start   (EN_start),
        .RDY_start  (RDY_start),
        .result     (result),
        .RDY_result (RDY_result),
        .EN_check   (EN_check),
        .check      (check),
        .RDY_check  (RDY_check)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        logic [2*W-1:0] p;
        case (op)
            2'd0:    p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
            2'd1:    p = {{W{1'b0}}, a} - {{W{1'b0}}, b};
            2'd2:    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            default: p = {{W{1'b0}}, a ^ b};
        endcase
        return p[W-1:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        int t;
        t = 0;
        while (!RDY_start && t < 100) begin
            tick();
            t++;
        end
        n_cmp++;
        if (RDY_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready_timeout: RDY_start=%b required 1", RDY_start);
        end
        start_a  = a;
        start_b  = b;
        start_op = op;
        EN_start = 1'b1;
        sb.push_back(model(a, b, op));
        tick();
        EN_start = 1'b0;
    endtask

    task automatic do_pop(input string name);
        int t;
        logic [W-1:0] exp;
        t = 0;
        while (!RDY_check && t < 100) begin
            tick();
            t++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (RDY_check !== 1'b1 || check !== exp) begin
            n_fail++;
            $display("FAIL %s: RDY_check=%b check=0x%03h required RDY_check=1 check=0x%03h",
                     name, RDY_check, check, exp);
        end
        EN_check = 1'b1;
        tick();
        EN_check = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        n_cmp++;
        if ({RDY_start, RDY_result, RDY_check} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ready: {start,result,check}=%b required 100",
                     {RDY_start, RDY_result, RDY_check});
        end
        n_cmp++;
        if (result !== '0 || check !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=0x%03h check=0x%03h required 0", result, check);
        end
    endtask

    task automatic test_add_wrap();
        do_start(11'h7FF, 11'h001, 2'd0);
        n_cmp++;
        if (RDY_start !== 1'b0 || RDY_result !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy: RDY_start=%b RDY_result=%b required 0 0", RDY_start, RDY_result);
        end
        tick();
        n_cmp++;
        if (RDY_result !== 1'b1 || result !== 11'h000 || RDY_start !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency: RDY_result=%b result=0x%03h RDY_start=%b required 1 0x000 1",
                     RDY_result, result, RDY_start);
        end
        do_pop("add_wrap_check");
        n_cmp++;
        if (RDY_result !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drained: RDY_result=%b required 0", RDY_result);
        end
    endtask

    task automatic test_sub_mul();
        int busy_bad;
        do_start(11'h002, 11'h005, 2'd1);
        tick();
        n_cmp++;
        if (result !== 11'h7FD) begin
            n_fail++;
            $display("FAIL sub_result: result=0x%03h required 0x7fd", result);
        end
        do_pop("sub_check");
        do_start(11'd3, 11'd5, 2'd2);
        busy_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (RDY_start !== 1'b0 || RDY_result !== 1'b0) busy_bad++;
            tick();
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL mul_busy_window: bad_samples=%0d required 0", busy_bad);
        end
        n_cmp++;
        if (RDY_start !== 1'b1 || RDY_result !== 1'b1 || result !== 11'h00F) begin
            n_fail++;
            $display("FAIL mul_latency: RDY_start=%b RDY_result=%b result=0x%03h required 1 1 0x00f",
                     RDY_start, RDY_result, result);
        end
        do_pop("mul_3x5_check");
    endtask

    task automatic test_mul_xor();
        do_start(11'h7FF, 11'h7FF, 2'd2);
        do_start(11'h5A5, 11'h0FF, 2'd3);
        do_pop("mul_max_check");
        do_pop("xor_check");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        do_start(11'd1, 11'd1, 2'd0);
        do_start(11'd2, 11'd2, 2'd0);
        do_start(11'd3, 11'd3, 2'd0);
        tick();
        tick();
        n_cmp++;
        if (RDY_start !== 1'b0 || RDY_result !== 1'b1) begin
            n_fail++;
            $display("FAIL full_backpressure: RDY_start=%b RDY_result=%b required 0 1",
                     RDY_start, RDY_result);
        end
        exp = sb.pop_front();
        n_cmp++;
        if (check !== exp) begin
            n_fail++;
            $display("FAIL passthrough_head: check=0x%03h required 0x%03h", check, exp);
        end
        EN_check = 1'b1;
        tick();
        EN_check = 1'b0;
        n_cmp++;
        if (RDY_start !== 1'b1 || RDY_result !== 1'b1) begin
            n_fail++;
            $display("FAIL passthrough_after: RDY_start=%b RDY_result=%b required 1 1",
                     RDY_start, RDY_result);
        end
        do_pop("full_second");
        do_pop("full_third");
        n_cmp++;
        if (RDY_check !== 1'b0) begin
            n_fail++;
            $display("FAIL full_count: RDY_check=%b after draining required 0", RDY_check);
        end
    endtask

    task automatic test_ignored();
        int bad;
        bad = 0;
        EN_check = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (RDY_check !== 1'b0 || result !== '0) bad++;
        end
        EN_check = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL deq_when_empty: bad_samples=%0d required 0", bad);
        end
        do_start(11'd10, 11'd20, 2'd0);
        do_start(11'd6, 11'd7, 2'd2);
        bad = 0;
        start_a  = 11'h123;
        start_b  = 11'h045;
        start_op = 2'd3;
        EN_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (RDY_start !== 1'b0) bad++;
            tick();
        end
        EN_start = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL start_while_busy: bad_samples=%0d required 0", bad);
        end
        do_pop("order_first");
        do_pop("order_second");
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (RDY_check !== 1'b0 || RDY_start !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_enqueue: RDY_check=%b RDY_start=%b required 0 1",
                     RDY_check, RDY_start);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_start(11'd1, 11'd2, 2'd0);
        do_start(11'd4, 11'd5, 2'd2);
        tick();
        tick();
        n_cmp++;
        if (RDY_result !== 1'b1 || RDY_start !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: RDY_result=%b RDY_start=%b required 1 0", RDY_result, RDY_start);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({RDY_start, RDY_result, RDY_check} !== 3'b100 || result !== '0 || check !== '0) begin
            n_fail++;
            $display("FAIL async_reset: {start,result,check}=%b result=0x%03h check=0x%03h required 100 0 0",
                     {RDY_start, RDY_result, RDY_check}, result, check);
        end
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        n_cmp++;
        if (RDY_start !== 1'b1 || RDY_result !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: RDY_start=%b RDY_result=%b required 1 0", RDY_start, RDY_result);
        end
        do_start(11'h010, 11'h003, 2'd1);
        do_pop("after_reset_sub");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_mul();
        test_mul_xor();
        test_back_to_back();
        test_ignored();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_unit_fifo.md
Name: arith_unit_fifo

Overview:
- Parametrised successor of the fixed 11-bit start/result/check design.
- Accepts two WIDTH-bit operands and an opcode through a start method.
- Computes add, sub or xor in one cycle, or an iterative shift-add multiply in WIDTH cycles.
- Queues results in a DEPTH-entry output FIFO, read through a peek method (result) and a dequeue method (check). All methods use enable/ready handshakes.

Parameters:
- WIDTH, 11, operand and result width in bits (>=2).
- DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- start_a  in  WIDTH  operand A.
- start_b  in  WIDTH  operand B.
- start_op  in  2  opcode: 0 add, 1 sub (A-B), 2 mul, 3 xor.
- EN_start  in  1  start enable.
- RDY_start  out  1  start ready.
- result  out  WIDTH  FIFO head value (peek).
- RDY_result  out  1  FIFO non-empty.
- EN_check  in  1  dequeue enable.
- check  out  WIDTH  FIFO head value returned by the dequeue.
- RDY_check  out  1  FIFO non-empty.

Behaviour:
- Reset (RST_N=0, asynchronous, any state including mid-multiply):
  - state=IDLE; FIFO empty (pointers and count 0); datapath registers 0.
  - Outputs: RDY_start=1, RDY_result=0, RDY_check=0, result=0, check=0.
- Start handshake:
  - Start fires only when EN_start && RDY_start; EN_start while RDY_start=0 is ignored.
  - RDY_start = (state==IDLE). Only one operation is in flight.
- FSM states: IDLE, MUL, WB.
  - IDLE, start fires at edge E:
    - op 0/1/3: result register <= A+B, A-B or A^B, mod 2^WIDTH; go to WB.
    - op 2: acc<=0, ma<=A, mb<=B, cnt<=WIDTH; go to MUL.
  - MUL, each edge:
    - if mb[0]: acc <= acc+ma (mod 2^WIDTH).
    - ma <= ma<<1; mb <= mb>>1; cnt <= cnt-1.
    - When cnt==1, the update is the last iteration; go to WB. The product is the low WIDTH bits.
  - WB:
    - Enqueue when (count<DEPTH) || (EN_check && count!=0); go to IDLE.
    - Otherwise hold in WB with RDY_start=0 (backpressure).
- Latency, start accepted at edge E:
  - add/sub/xor enqueue at edge E+1; mul enqueue at edge E+WIDTH+1 (no backpressure).
  - RDY_start is high again immediately after the enqueue edge.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - result and check are both driven combinationally from the head entry. Both read 0 when empty (the entry is masked).
  - Dequeue fires on EN_check && RDY_check; EN_check while empty is ignored.
  - Enqueue and dequeue in the same cycle leave the count unchanged. This is allowed while full (pass-through); the dequeued value is the old head.
- No combinational path from EN_start to any RDY output. RDY_result and RDY_check depend only on the FIFO count.

Decomposition:
- Shared package holds:
  - opcode enum (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_XOR=3);
  - FSM state enum (IDLE, MUL, WB);
  - function clog2 for the pointer and counter widths.
- One sub-module: result_fifo, parameters WIDTH and DEPTH.
  - Ports: enq, enq_data, deq, head, not_empty, not_full, count.
  - Implements the simultaneous enq/deq-when-full rule.
- The FSM and datapath live in the top module.

Test Plan:
1. Reset (WIDTH=11, DEPTH=2), then release -> RDY_start=1, RDY_result=0, RDY_check=0, result=0. Assert RST_N=0 mid-MUL -> all outputs return to reset values in the same cycle.
2. start op=add, A=0x7FF, B=0x001 at edge E -> at edge E+1 RDY_result=1, result=0x000 (wrap); EN_check one cycle -> check=0x000, then RDY_result=0.
3. start op=sub, A=0x002, B=0x005 -> result=0x7FD. Then op=mul, A=3, B=5 at edge E -> RDY_start=0 for edges E..E+11, enqueue at E+12, result=0x00F.
4. op=mul A=0x7FF B=0x7FF -> result=0x001 (low 11 bits of 0x3FF001). Then op=xor A=0x5A5 B=0x0FF -> 0x55A.
5. Three add ops with no check -> FIFO full after 2; third waits in WB with RDY_start=0. Assert EN_check -> first result dequeued and third enqueued on the same edge; count stays 2; RDY_start=1 next cycle.
6. Assert EN_start while busy and EN_check while empty -> no state change, no spurious enqueue/dequeue, FIFO order preserved.
